// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter.
//
// Serialises one DATA_BITS-wide word per valid/ready transfer onto `tx`.
// Frame: start bit (0), data LSB first, optional even parity, STOP_BITS
// stop bits (1). Every bit lasts PERIOD = CLK_FREQ/BAUD_RATE cycles.
// All outputs come straight from flops, and the line idles high.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits. Parity is computed when the word is accepted. Without
// the macro there is no parity state and no parity logic.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   data       in   word to transmit, sampled on transfer
//   data_valid in   upstream has a word
//   data_ready out  block can accept a word (high in IDLE)
//   tx         out  serial line, idle high
//   busy       out  frame in progress
module uart_tx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(PERIOD - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    generate
        if (PERIOD < 2) begin : g_period_check
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     clk_count;
    logic [BIT_W-1:0]     bit_count;   // data bit index, reused to count stop bits
    logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    // The next tx value is loaded at each bit boundary, so tx always comes
    // from a flop and never from state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            clk_count  <= '0;
            bit_count  <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            data_ready <= 1'b1;
            busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_valid && data_ready) begin
                        shift      <= data;
`ifdef UART_TX_PARITY_EN
                        parity     <= ^data;
`endif
                        clk_count  <= '0;
                        bit_count  <= '0;
                        state      <= S_START;
                        tx         <= 1'b0;
                        data_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        bit_count <= '0;
                        state     <= S_DATA;
                        tx        <= shift[0];
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                S_DATA: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        if (bit_count == LAST_DATA) begin
                            bit_count <= '0;
`ifdef UART_TX_PARITY_EN
                            state     <= S_PARITY;
                            tx        <= parity;
`else
                            state     <= S_STOP;
                            tx        <= 1'b1;
`endif
                        end else begin
                            bit_count <= bit_count + 1'b1;
                            shift     <= shift >> 1;
                            // shift[1] becomes shift[0] after this edge
                            tx        <= shift[1];
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        bit_count <= '0;
                        state     <= S_STOP;
                        tx        <= 1'b1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (clk_count == LAST_CLK) begin
                        clk_count <= '0;
                        if (bit_count == LAST_STOP) begin
                            bit_count  <= '0;
                            state      <= S_IDLE;
                            data_ready <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            bit_count <= bit_count + 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    clk_count  <= '0;
                    bit_count  <= '0;
                    tx         <= 1'b1;
                    data_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
